// File: rtl/mem_seq_if.sv
// Bundle between the memory test sequencer and its environment: run control,
// memory-side bus and result reporting.
interface mem_seq_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 13
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_cnt;
    logic [DATA_W-1:0] seed;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W-1:0] err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        output start, base_addr, word_cnt, seed, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, busy, done, pass, err_cnt, first_err_addr
    );

    modport slave (
        input  start, base_addr, word_cnt, seed, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, busy, done, pass, err_cnt, first_err_addr
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Self-checking memory sequencer: writes seed+i over a window of addresses,
// reads it back and reports pass, error count and first failing address.
module mem_seq_ctrl #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 1
) (
    input logic    clk,
    input logic    rst,
    mem_seq_if.slave bus
);
    localparam int DRW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_q, base_n, n_q, n_n, idx_q, idx_n;
    logic [DATA_W-1:0] seed_q, seed_n, exp_q, exp_n;
    logic [DRW-1:0]    drain_q, drain_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              we_q, we_n, re_q, re_n;
    logic              busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic [ADDR_W-1:0] err_q, err_n, first_q, first_n;
    logic              chk_fail;

    // Compare pipeline: one slot per cycle of read latency
    logic              pipe_vld  [RD_LAT];
    logic [DATA_W-1:0] pipe_exp  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];

    always_comb begin
        chk_fail = pipe_vld[RD_LAT-1] && (bus.mem_rdata != pipe_exp[RD_LAT-1]);
        state_n  = state;
        base_n   = base_q;
        n_n      = n_q;
        seed_n   = seed_q;
        idx_n    = idx_q;
        exp_n    = exp_q;
        drain_n  = drain_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        we_n     = 1'b0;
        re_n     = 1'b0;
        busy_n   = busy_q;
        done_n   = 1'b0;
        pass_n   = pass_q;
        err_n    = err_q;
        first_n  = first_q;

        if (chk_fail) begin
            if (err_q != {ADDR_W{1'b1}})
                err_n = err_q + ADDR_W'(1);
            if (err_q == '0)
                first_n = pipe_addr[RD_LAT-1];
        end

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.start) begin
                    base_n  = bus.base_addr;
                    n_n     = bus.word_cnt;
                    seed_n  = bus.seed;
                    idx_n   = '0;
                    err_n   = '0;
                    first_n = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    if (bus.word_cnt == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        addr_n  = bus.base_addr;
                        wdata_n = bus.seed;
                    end
                end
            end
            WRITE: begin
                if (idx_q == n_q - ADDR_W'(1)) begin
                    state_n = READ;
                    re_n    = 1'b1;
                    idx_n   = '0;
                    addr_n  = base_q;
                    exp_n   = seed_q;
                end else begin
                    we_n    = 1'b1;
                    idx_n   = idx_q + ADDR_W'(1);
                    addr_n  = addr_q + ADDR_W'(1);
                    wdata_n = wdata_q + DATA_W'(1);
                end
            end
            READ: begin
                if (idx_q == n_q - ADDR_W'(1)) begin
                    state_n = DRAIN;
                    drain_n = '0;
                end else begin
                    re_n   = 1'b1;
                    idx_n  = idx_q + ADDR_W'(1);
                    addr_n = addr_q + ADDR_W'(1);
                    exp_n  = exp_q + DATA_W'(1);
                end
            end
            DRAIN: begin
                // The final compare lands on this edge, so pass uses the updated count
                if (drain_q == DRW'(RD_LAT - 1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end else begin
                    drain_n = drain_q + DRW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            drain_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                pipe_vld[j]  <= 1'b0;
                pipe_exp[j]  <= '0;
                pipe_addr[j] <= '0;
            end
        end else begin
            state   <= state_n;
            base_q  <= base_n;
            n_q     <= n_n;
            seed_q  <= seed_n;
            idx_q   <= idx_n;
            exp_q   <= exp_n;
            drain_q <= drain_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            re_q    <= re_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
            first_q <= first_n;
            pipe_vld[0]  <= re_q;
            pipe_exp[0]  <= exp_q;
            pipe_addr[0] <= addr_q;
            for (int j = 1; j < RD_LAT; j++) begin
                pipe_vld[j]  <= pipe_vld[j-1];
                pipe_exp[j]  <= pipe_exp[j-1];
                pipe_addr[j] <= pipe_addr[j-1];
            end
        end
    end

    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_re         = re_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_q;
    assign bus.first_err_addr = first_q;
endmodule
